// File: rtl/axi_mem_slave_pkg.sv
// Shared types and constants for the AXI data-memory responder.
//  - bus widths, burst and response codes
//  - ax_req_t: latched address-channel request
//  - cfg_err / next_addr: per-burst checks and the address stepper
package axi_mem_slave_pkg;

  localparam int unsigned BUS_ADDR_MEM = 64;
  localparam int unsigned BUS_DATA_MEM = 64;
  localparam int unsigned BUS_AXI_STRB = BUS_DATA_MEM / 8;
  localparam int unsigned WORD_SHIFT   = $clog2(BUS_AXI_STRB);

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic AXI_RESP_OKAY = 1'b0;
  localparam logic AXI_RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  typedef struct packed {
    logic                    id;
    logic [BUS_ADDR_MEM-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ax_req_t;

  // Burst-wide error: beat wider than the bus, or any burst type other than FIXED/INCR.
  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(WORD_SHIFT)) ||
           ((burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR));
  endfunction

  // FIXED holds the address; INCR steps by the beat size; WRAP and reserved fall back to INCR.
  function automatic logic [BUS_ADDR_MEM-1:0] next_addr(input logic [BUS_ADDR_MEM-1:0] addr,
                                                        input logic [2:0]              size,
                                                        input logic [1:0]              burst);
    logic [BUS_ADDR_MEM-1:0] step;
    step = BUS_ADDR_MEM'(1) << size;
    case (burst)
      AXI_BURST_FIXED: return addr;
      AXI_BURST_INCR:  return addr + step;
      AXI_BURST_WRAP:  return addr + step;
      default:         return addr + step;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Single-port-write / single-port-read RAM for the AXI data memory.
//  clk, rst_n        : clock, async active-low reset (read register only)
//  we/waddr/wdata/wstrb : byte-enabled write port
//  re/raddr          : synchronous read, result in rdata the next cycle
//  rclr              : load zero into rdata instead of reading (out-of-range beat)
//  rdata             : registered read data, holds until the next re/rclr
// A read and write of the same word on one edge returns the old contents.
module axi_mem_ram #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STRB_W = DATA_W / 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic              rclr,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register; non-blocking update gives read-first ordering against the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else if (rclr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder serving core load/store bursts from the on-chip data RAM.
// Write and read channels are independent FSMs sharing only the RAM.
//  clk, rst_n                         : clock, async active-low reset
//  aw*/w*/b*                          : write address, data, response channels
//  ar*/r*                             : read address, data channels
//  bresp/rresp                        : 0 OKAY, 1 SLVERR
// Write: W_IDLE -> W_DATA -> W_RESP. Read: R_IDLE -> R_FETCH -> R_DATA (1 beat / 2 cycles).
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int unsigned             MEM_DEPTH = 4096,
  parameter logic [BUS_ADDR_MEM-1:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic                    awid,
  input  logic [BUS_ADDR_MEM-1:0] awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [BUS_DATA_MEM-1:0] wdata,
  input  logic [BUS_AXI_STRB-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    bid,
  output logic                    bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic                    arid,
  input  logic [BUS_ADDR_MEM-1:0] araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    rid,
  output logic [BUS_DATA_MEM-1:0] rdata,
  output logic                    rresp,
  output logic                    rlast
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  // Address lies inside the RAM window.
  function automatic logic addr_ok(input logic [BUS_ADDR_MEM-1:0] a);
    logic [BUS_ADDR_MEM-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> WORD_SHIFT) < BUS_ADDR_MEM'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [BUS_ADDR_MEM-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> WORD_SHIFT);
  endfunction

  // ---------------- write channel ----------------
  w_state_e   w_state, w_state_nx;
  ax_req_t    w_req, w_req_nx;
  logic [7:0] w_beat, w_beat_nx;
  logic       w_err, w_err_nx;
  logic       awready_nx, wready_nx, bvalid_nx, bid_nx, bresp_nx;
  logic       w_beat_ok_c, w_last_c, ram_we_c;

  assign w_beat_ok_c = addr_ok(w_req.addr);
  assign w_last_c    = (w_beat == w_req.len);

  // Write state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_req   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= 1'b0;
      bresp   <= AXI_RESP_OKAY;
    end else begin
      w_state <= w_state_nx;
      w_req   <= w_req_nx;
      w_beat  <= w_beat_nx;
      w_err   <= w_err_nx;
      awready <= awready_nx;
      wready  <= wready_nx;
      bvalid  <= bvalid_nx;
      bid     <= bid_nx;
      bresp   <= bresp_nx;
    end
  end

  // Write next-state. The beat counter, not wlast, decides the end of the burst.
  always_comb begin
    w_state_nx = w_state;
    w_req_nx   = w_req;
    w_beat_nx  = w_beat;
    w_err_nx   = w_err;
    ram_we_c   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_req_nx   = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
          w_beat_nx  = '0;
          w_err_nx   = cfg_err(awsize, awburst);
          w_state_nx = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          ram_we_c = w_beat_ok_c;
          if (!w_beat_ok_c || (wlast != w_last_c)) w_err_nx = AXI_RESP_ERR;
          w_req_nx.addr = next_addr(w_req.addr, w_req.size, w_req.burst);
          w_beat_nx     = w_beat + 8'd1;
          if (w_last_c) w_state_nx = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid && bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
    awready_nx = (w_state_nx == W_IDLE);
    wready_nx  = (w_state_nx == W_DATA);
    bvalid_nx  = (w_state_nx == W_RESP);
    bresp_nx   = (w_state_nx == W_RESP) ? w_err_nx : AXI_RESP_OKAY;
    bid_nx     = w_req_nx.id;
  end

  // ---------------- read channel ----------------
  r_state_e   r_state, r_state_nx;
  ax_req_t    r_req, r_req_nx;
  logic [7:0] r_beat, r_beat_nx;
  logic       r_cfg_err, r_cfg_err_nx;
  logic       arready_nx, rvalid_nx, rid_nx, rresp_nx, rlast_nx;
  logic       r_beat_ok_c, r_last_c, ram_re_c, ram_rclr_c;

  assign r_beat_ok_c = addr_ok(r_req.addr);
  assign r_last_c    = (r_beat == r_req.len);

  // Read state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_req     <= '0;
      r_beat    <= '0;
      r_cfg_err <= 1'b0;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rid       <= 1'b0;
      rresp     <= AXI_RESP_OKAY;
      rlast     <= 1'b0;
    end else begin
      r_state   <= r_state_nx;
      r_req     <= r_req_nx;
      r_beat    <= r_beat_nx;
      r_cfg_err <= r_cfg_err_nx;
      arready   <= arready_nx;
      rvalid    <= rvalid_nx;
      rid       <= rid_nx;
      rresp     <= rresp_nx;
      rlast     <= rlast_nx;
    end
  end

  // Read next-state. Beat status is captured in R_FETCH so it lines up with the RAM output.
  always_comb begin
    r_state_nx   = r_state;
    r_req_nx     = r_req;
    r_beat_nx    = r_beat;
    r_cfg_err_nx = r_cfg_err;
    rresp_nx     = rresp;
    rlast_nx     = rlast;
    ram_re_c     = 1'b0;
    ram_rclr_c   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_req_nx     = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
          r_beat_nx    = '0;
          r_cfg_err_nx = cfg_err(arsize, arburst);
          r_state_nx   = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re_c   = r_beat_ok_c;
        ram_rclr_c = !r_beat_ok_c;
        rresp_nx   = (!r_beat_ok_c || r_cfg_err) ? AXI_RESP_ERR : AXI_RESP_OKAY;
        rlast_nx   = r_last_c;
        r_state_nx = R_DATA;
      end
      R_DATA: begin
        if (rvalid && rready) begin
          rresp_nx = AXI_RESP_OKAY;
          rlast_nx = 1'b0;
          if (rlast) begin
            r_state_nx = R_IDLE;
          end else begin
            r_req_nx.addr = next_addr(r_req.addr, r_req.size, r_req.burst);
            r_beat_nx     = r_beat + 8'd1;
            r_state_nx    = R_FETCH;
          end
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
    arready_nx = (r_state_nx == R_IDLE);
    rvalid_nx  = (r_state_nx == R_DATA);
    rid_nx     = r_req_nx.id;
  end

  // ---------------- storage ----------------
  axi_mem_ram #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (BUS_DATA_MEM),
    .STRB_W (BUS_AXI_STRB),
    .AW     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_c),
    .waddr (word_idx(w_req.addr)),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (ram_re_c),
    .rclr  (ram_rclr_c),
    .raddr (word_idx(r_req.addr)),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: single/INCR/FIXED bursts, byte strobes,
// out-of-range addresses, wlast mismatch, WRAP/size errors and bready back-pressure.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  localparam int LIM = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready, awid = 1'b0;
  logic [63:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready, wlast = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0, bid, bresp;
  logic        arvalid = 1'b0, arready, arid = 1'b0;
  logic [63:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 1'b0, rid, rresp, rlast;
  logic [63:0] rdata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] wr_data [16];
  logic [63:0] rd_data [16];
  logic        rd_resp [16];
  logic        rd_last [16];
  logic        got_bresp, got_bid, got_rid;

  axi_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left on a negedge; the DUT is sampled there too.
  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] strb,
                           input logic [15:0] last_mask, input logic id, input int hold);
    int n;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < LIM) begin @(negedge clk); n++; end
    check("tmo_aw", 64'(n >= LIM), 64'(0));
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wr_data[b]; wstrb = strb; wlast = last_mask[b]; wvalid = 1'b1;
      n = 0;
      while (!wready && n < LIM) begin @(negedge clk); n++; end
      check("tmo_w", 64'(n >= LIM), 64'(0));
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = (hold == 0);
    n = 0;
    while (!bvalid && n < LIM) begin @(negedge clk); n++; end
    check("tmo_b", 64'(n >= LIM), 64'(0));
    for (int k = 0; k < hold; k++) begin
      check("b_hold_bvalid", 64'(bvalid), 64'(1));
      check("b_hold_awready", 64'(awready), 64'(0));
      @(negedge clk);
    end
    got_bresp = bresp; got_bid = bid;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id);
    int n;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIM) begin @(negedge clk); n++; end
    check("tmo_ar", 64'(n >= LIM), 64'(0));
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < LIM) begin @(negedge clk); n++; end
      check("tmo_r", 64'(n >= LIM), 64'(0));
      rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; got_rid = rid;
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // 1. reset
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_bvalid",  64'(bvalid),  64'(0));
    check("rst_rvalid",  64'(rvalid),  64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready", 64'(awready), 64'(1));
    check("rel_arready", 64'(arready), 64'(1));
    check("rel_wready",  64'(wready),  64'(0));
    check("rel_bvalid",  64'(bvalid),  64'(0));
    check("rel_rvalid",  64'(rvalid),  64'(0));

    // 2. single beat
    wr_data[0] = 64'h1122334455667788;
    axi_write(64'h8000_0010, 8'd0, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b0, 0);
    check("t2_bresp", 64'(got_bresp), 64'(0));
    axi_read(64'h8000_0010, 8'd0, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t2_rdata", rd_data[0], 64'h1122334455667788);
    check("t2_rlast", 64'(rd_last[0]), 64'(1));
    check("t2_rresp", 64'(rd_resp[0]), 64'(0));

    // 3. four-beat INCR
    for (int i = 0; i < 4; i++) wr_data[i] = 64'(i + 1);
    axi_write(64'h8000_0000, 8'd3, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0008, 1'b0, 0);
    check("t3_bresp", 64'(got_bresp), 64'(0));
    axi_read(64'h8000_0000, 8'd3, 3'd3, AXI_BURST_INCR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t3_rdata", rd_data[i], 64'(i + 1));
      check("t3_rlast", 64'(rd_last[i]), 64'(i == 3));
      check("t3_rresp", 64'(rd_resp[i]), 64'(0));
    end

    // 4. partial strobe over a zeroed word
    wr_data[0] = 64'h0;
    axi_write(64'h8000_0100, 8'd0, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b0, 0);
    wr_data[0] = 64'hAAAAAAAA_BBBBBBBB;
    axi_write(64'h8000_0100, 8'd0, 3'd3, AXI_BURST_INCR, 8'h0F, 16'h0001, 1'b0, 0);
    check("t4_bresp", 64'(got_bresp), 64'(0));
    axi_read(64'h8000_0100, 8'd0, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t4_rdata", rd_data[0], 64'h00000000_BBBBBBBB);

    // 5. below the window, then above it, then the last valid word
    wr_data[0] = 64'hDEADBEEF_CAFEF00D;
    axi_write(64'h7FFF_FFF8, 8'd0, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b0, 0);
    check("t5_lo_bresp", 64'(got_bresp), 64'(1));
    axi_read(64'h7FFF_FFF8, 8'd0, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t5_lo_rdata", rd_data[0], 64'h0);
    check("t5_lo_rresp", 64'(rd_resp[0]), 64'(1));
    axi_read(64'h8000_0000, 8'd0, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t5_unchanged", rd_data[0], 64'h1);
    axi_write(64'h8000_8000, 8'd0, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b0, 0);
    check("t5_hi_bresp", 64'(got_bresp), 64'(1));
    axi_read(64'h8000_8000, 8'd0, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t5_hi_rdata", rd_data[0], 64'h0);
    check("t5_hi_rresp", 64'(rd_resp[0]), 64'(1));
    wr_data[0] = 64'h0123_4567_89AB_CDEF;
    axi_write(64'h8000_7FF8, 8'd0, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b0, 0);
    check("t5_top_bresp", 64'(got_bresp), 64'(0));
    axi_read(64'h8000_7FF8, 8'd0, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t5_top_rdata", rd_data[0], 64'h0123_4567_89AB_CDEF);
    check("t5_top_rresp", 64'(rd_resp[0]), 64'(0));

    // 6. early wlast with bready held off for 5 cycles
    wr_data[0] = 64'h11; wr_data[1] = 64'h22;
    axi_write(64'h8000_0400, 8'd1, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b0, 5);
    check("t6_bresp", 64'(got_bresp), 64'(1));
    check("t6_awready_after_b", 64'(awready), 64'(1));
    axi_read(64'h8000_0400, 8'd1, 3'd3, AXI_BURST_INCR, 1'b0);
    check("t6_beat0", rd_data[0], 64'h11);
    check("t6_beat1", rd_data[1], 64'h22);

    // missing wlast
    axi_write(64'h8000_0480, 8'd1, 3'd3, AXI_BURST_INCR, 8'hFF, 16'h0000, 1'b0, 0);
    check("nolast_bresp", 64'(got_bresp), 64'(1));

    // WRAP behaves as INCR but errors
    wr_data[0] = 64'h55; wr_data[1] = 64'h66;
    axi_write(64'h8000_0500, 8'd1, 3'd3, AXI_BURST_WRAP, 8'hFF, 16'h0002, 1'b0, 0);
    check("wrap_bresp", 64'(got_bresp), 64'(1));
    axi_read(64'h8000_0500, 8'd1, 3'd3, AXI_BURST_INCR, 1'b0);
    check("wrap_beat0", rd_data[0], 64'h55);
    check("wrap_beat1", rd_data[1], 64'h66);
    check("wrap_rresp_incr", 64'(rd_resp[1]), 64'(0));
    axi_read(64'h8000_0500, 8'd1, 3'd3, AXI_BURST_WRAP, 1'b0);
    check("wrap_rresp0", 64'(rd_resp[0]), 64'(1));
    check("wrap_rresp1", 64'(rd_resp[1]), 64'(1));

    // FIXED: both beats land on the same word
    wr_data[0] = 64'hA; wr_data[1] = 64'hB;
    axi_write(64'h8000_0600, 8'd1, 3'd3, AXI_BURST_FIXED, 8'hFF, 16'h0002, 1'b0, 0);
    check("fixed_bresp", 64'(got_bresp), 64'(0));
    axi_read(64'h8000_0600, 8'd1, 3'd3, AXI_BURST_FIXED, 1'b0);
    check("fixed_beat0", rd_data[0], 64'hB);
    check("fixed_beat1", rd_data[1], 64'hB);
    check("fixed_last1", 64'(rd_last[1]), 64'(1));

    // oversize beat and id echo
    wr_data[0] = 64'h77;
    axi_write(64'h8000_0700, 8'd0, 3'd4, AXI_BURST_INCR, 8'hFF, 16'h0001, 1'b1, 0);
    check("size_bresp", 64'(got_bresp), 64'(1));
    check("bid_echo", 64'(got_bid), 64'(1));
    axi_read(64'h8000_0000, 8'd0, 3'd3, AXI_BURST_INCR, 1'b1);
    check("rid_echo", 64'(got_rid), 64'(1));
    axi_read(64'h8000_0000, 8'd0, 3'd4, AXI_BURST_INCR, 1'b0);
    check("size_rresp", 64'(rd_resp[0]), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
